dcache_mem_responder: RTL and testbench



---
 rtl/dcache_blocking_pkg.sv | 40 ++++
 rtl/dcache_mem_if.sv | 29 ++
 rtl/dcache_mem_responder_store.sv | 25 ++
 rtl/dcache_mem_responder.sv | 157 +++++++++++++++
 tb/tb_dcache_mem_responder.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/dcache_blocking_pkg.sv
// Shared types for the blocking dcache and its memory-side responder.
// Address views: .l splits line number / byte-in-line, .p adds the beat bank.
package dcache_blocking_pkg;

   localparam int ADDR_W         = 32;
   localparam int MEM_DATA_W     = 64;
   localparam int RAM_DAT_LINE_N = 4;
   localparam int RAM_DAT_LINE_W = $clog2(RAM_DAT_LINE_N);
   localparam int LINE_OFF_W     = 5;
   localparam int BEAT_OFF_W     = 3;
   localparam int MEM_BEATS_N    = RAM_DAT_LINE_N;

   typedef logic [MEM_DATA_W-1:0]     mem_data_t;
   typedef logic [RAM_DAT_LINE_W-1:0] ram_dat_line_t;

   typedef struct packed {
      logic [ADDR_W-LINE_OFF_W-1:0] o;
      logic [LINE_OFF_W-1:0]        off;
   } addr_line_t;

   typedef struct packed {
      logic [ADDR_W-LINE_OFF_W-1:0] o;
      ram_dat_line_t                b;
      logic [BEAT_OFF_W-1:0]        off;
   } addr_beat_t;

   typedef union packed {
      addr_line_t        l;
      addr_beat_t        p;
      logic [ADDR_W-1:0] raw;
   } addr_t;

   typedef struct packed {
      logic  wr;
      addr_t addr;
   } mem_req_t;

   typedef enum logic [2:0] {IDLE, RLAT, RBEAT, WBEAT, WACK} mem_rsp_state_t;

endpackage

// File: rtl/dcache_mem_if.sv
// Line-fill / writeback bus between the dcache miss path (master) and memory (slave).
interface dcache_mem_if;
   import dcache_blocking_pkg::*;

   logic          req_vld;
   logic          req_rdy;
   logic          req_wr;
   addr_t         req_addr;
   logic          wdat_vld;
   logic          wdat_rdy;
   mem_data_t     wdat;
   logic          rsp_vld;
   logic          rsp_rdy;
   mem_data_t     rsp_dat;
   ram_dat_line_t rsp_beat;
   logic          rsp_last;
   logic          wack;

   modport master (
      output req_vld, req_wr, req_addr, wdat_vld, wdat, rsp_rdy,
      input  req_rdy, wdat_rdy, rsp_vld, rsp_dat, rsp_beat, rsp_last, wack
   );

   modport slave (
      input  req_vld, req_wr, req_addr, wdat_vld, wdat, rsp_rdy,
      output req_rdy, wdat_rdy, rsp_vld, rsp_dat, rsp_beat, rsp_last, wack
   );

endinterface

// File: rtl/dcache_mem_responder_store.sv
// Backing store: 1R1W block RAM with registered read, addressed {line, bank}.
module dcache_mem_store
   import dcache_blocking_pkg::*;
#(
   parameter int DEPTH = 4096,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  mem_data_t     wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output mem_data_t     rdata
);

   mem_data_t mem_array [DEPTH];

   // Output holds between read enables so a stalled beat stays stable.
   always_ff @(posedge clk) begin
      if (we) mem_array[waddr] <= wdata;
      if (re) rdata <= mem_array[raddr];
   end

endmodule

// File: rtl/dcache_mem_responder.sv
// Memory responder serving dcache line fills and writebacks from a local store.
// Optional DCACHE_MEM_RESPONDER_CWF_EN: fills start at the requested bank (critical word first).
module dcache_mem_responder
   import dcache_blocking_pkg::*;
#(
   parameter int MEM_LINES_N = 1024,
   parameter int RSP_LAT     = 4
) (
   input logic         clk,
   input logic         rst_n,
   dcache_mem_if.slave mem
);

   localparam int LINE_W   = $clog2(MEM_LINES_N);
   localparam int STORE_AW = LINE_W + RAM_DAT_LINE_W;
   localparam int LAT_W    = $clog2(RSP_LAT) + 1;
   localparam ram_dat_line_t LAST_BEAT = ram_dat_line_t'(MEM_BEATS_N - 1);
   localparam ram_dat_line_t ONE_BEAT  = ram_dat_line_t'(1);

   mem_rsp_state_t      state_reg, state_next;
   logic [LINE_W-1:0]   line_reg, line_next;
   ram_dat_line_t       start_reg, start_next;
   ram_dat_line_t       cnt_reg, cnt_next;
   logic [LAT_W-1:0]    lat_reg, lat_next;

   mem_req_t            req;
   ram_dat_line_t       req_start;
   ram_dat_line_t       bank, bank_inc;
   logic                req_hs, wdat_hs, rsp_hs;
   logic                st_we, st_re;
   logic [STORE_AW-1:0] st_waddr, st_raddr;
   mem_data_t           st_rdata;
   logic                unused_addr_bits;

   assign req      = '{wr: mem.req_wr, addr: mem.req_addr};
   assign bank     = start_reg + cnt_reg;
   assign bank_inc = bank + ONE_BEAT;
   assign req_hs   = (state_reg == IDLE)  && mem.req_vld;
   assign wdat_hs  = (state_reg == WBEAT) && mem.wdat_vld;
   assign rsp_hs   = (state_reg == RBEAT) && mem.rsp_rdy;

`ifdef DCACHE_MEM_RESPONDER_CWF_EN
   assign req_start = req.addr.p.b;
`else
   assign req_start = '0;
`endif

   // Tag bits above the index alias; byte offsets never select anything.
   assign unused_addr_bits = ^{req.addr.raw};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         line_reg  <= '0;
         start_reg <= '0;
         cnt_reg   <= '0;
         lat_reg   <= '0;
      end else begin
         state_reg <= state_next;
         line_reg  <= line_next;
         start_reg <= start_next;
         cnt_reg   <= cnt_next;
         lat_reg   <= lat_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      line_next  = line_reg;
      start_next = start_reg;
      cnt_next   = cnt_reg;
      lat_next   = lat_reg;
      st_re      = 1'b0;
      st_raddr   = {line_reg, bank};
      case (state_reg)
         IDLE: begin
            if (req_hs) begin
               line_next = req.addr.l.o[LINE_W-1:0];
               cnt_next  = '0;
               if (req.wr) begin
                  start_next = '0;
                  state_next = WBEAT;
               end else begin
                  start_next = req_start;
                  lat_next   = LAT_W'(RSP_LAT - 1);
                  state_next = RLAT;
               end
            end
         end
         RLAT: begin
            lat_next = lat_reg - LAT_W'(1);
            // Read issued one cycle early so the registered RAM output lands with rsp_vld.
            if (lat_reg == LAT_W'(1)) begin
               st_re      = 1'b1;
               state_next = RBEAT;
            end
         end
         RBEAT: begin
            if (rsp_hs) begin
               cnt_next = cnt_reg + ONE_BEAT;
               if (cnt_reg == LAST_BEAT) begin
                  state_next = IDLE;
               end else begin
                  st_re    = 1'b1;
                  st_raddr = {line_reg, bank_inc};
               end
            end
         end
         WBEAT: begin
            if (wdat_hs) begin
               cnt_next = cnt_reg + ONE_BEAT;
               if (cnt_reg == LAST_BEAT) state_next = WACK;
            end
         end
         WACK:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      mem.req_rdy  = 1'b0;
      mem.wdat_rdy = 1'b0;
      mem.rsp_vld  = 1'b0;
      mem.rsp_dat  = '0;
      mem.rsp_beat = '0;
      mem.rsp_last = 1'b0;
      mem.wack     = 1'b0;
      st_we        = wdat_hs;
      st_waddr     = {line_reg, cnt_reg};
      case (state_reg)
         IDLE:  mem.req_rdy  = 1'b1;
         RBEAT: begin
            mem.rsp_vld  = 1'b1;
            mem.rsp_dat  = st_rdata;
            mem.rsp_beat = bank;
            mem.rsp_last = (cnt_reg == LAST_BEAT);
         end
         WBEAT: mem.wdat_rdy = 1'b1;
         WACK:  mem.wack     = 1'b1;
         default: ;
      endcase
   end

   dcache_mem_store #(
      .DEPTH (MEM_LINES_N * MEM_BEATS_N),
      .AW    (STORE_AW)
   ) u_store (
      .clk   (clk),
      .we    (st_we),
      .waddr (st_waddr),
      .wdata (mem.wdat),
      .re    (st_re),
      .raddr (st_raddr),
      .rdata (st_rdata)
   );

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Directed bench for dcache_mem_responder: scoreboard of expected fill beats vs. DUT output.
module tb_dcache_mem_responder;
   import dcache_blocking_pkg::*;

   localparam int MEM_LINES_N = 1024;
   localparam int RSP_LAT     = 4;
   localparam int TMO         = 50;

   typedef struct {
      logic [63:0] dat;
      logic [1:0]  beat;
      logic        last;
   } exp_beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dcache_mem_if mem_bus ();

   dcache_mem_responder #(
      .MEM_LINES_N (MEM_LINES_N),
      .RSP_LAT     (RSP_LAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mem   (mem_bus)
   );

   exp_beat_t   sb_q [$];
   logic [63:0] model [int];
   int          n_assert = 0;
   int          n_fail   = 0;
   logic [63:0] da [4];
   logic [63:0] db [4];
   logic [63:0] dc [4];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int line_key(input logic [31:0] a, input int bank);
      return int'((a >> 5) & (MEM_LINES_N - 1)) * 4 + bank;
   endfunction

   function automatic int start_bank(input logic [31:0] a);
`ifdef DCACHE_MEM_RESPONDER_CWF_EN
      return int'((a >> 3) & 32'd3);
`else
      return (a == 32'hFFFF_FFFF) ? 0 : 0;
`endif
   endfunction

   // Tasks start and end just after a falling edge.
   task automatic write_line(input logic [31:0] addr, input logic [63:0] d [4]);
      int t;
      mem_bus.req_vld  = 1'b1;
      mem_bus.req_wr   = 1'b1;
      mem_bus.req_addr = addr;
      t = 0;
      while (!mem_bus.req_rdy && t < TMO) begin @(negedge clk); t++; end
      check("wr_req_rdy", mem_bus.req_rdy, 1);
      @(posedge clk); @(negedge clk);
      mem_bus.req_vld = 1'b0;
      for (int b = 0; b < 4; b++) begin
         mem_bus.wdat_vld = 1'b1;
         mem_bus.wdat     = d[b];
         t = 0;
         while (!mem_bus.wdat_rdy && t < TMO) begin @(negedge clk); t++; end
         check("wdat_rdy", mem_bus.wdat_rdy, 1);
         model[line_key(addr, b)] = d[b];
         @(posedge clk); @(negedge clk);
         if (b < 3) check("wack_early", mem_bus.wack, 0);
      end
      mem_bus.wdat_vld = 1'b0;
      check("wack", mem_bus.wack, 1);
      $display("write addr=%08h beats=%016h %016h %016h %016h", addr, d[0], d[1], d[2], d[3]);
   endtask

   task automatic read_line(input logic [31:0] addr, input int stall_beat, input int stall_n,
                            input int abort_beat, input bit poke);
      int t;
      int st;
      exp_beat_t e;
      st = start_bank(addr);
      for (int i = 0; i < 4; i++) begin
         e.dat  = model[line_key(addr, (st + i) % 4)];
         e.beat = 2'((st + i) % 4);
         e.last = (i == 3);
         sb_q.push_back(e);
      end
      mem_bus.req_vld  = 1'b1;
      mem_bus.req_wr   = 1'b0;
      mem_bus.req_addr = addr;
      t = 0;
      while (!mem_bus.req_rdy && t < TMO) begin @(negedge clk); t++; end
      check("rd_req_rdy", mem_bus.req_rdy, 1);
      @(posedge clk); @(negedge clk);
      mem_bus.req_vld = 1'b0;
      t = 1;
      while (!mem_bus.rsp_vld && t < TMO) begin @(negedge clk); t++; end
      check("first_lat", t, RSP_LAT);
      for (int i = 0; i < 4; i++) begin
         e = sb_q[0];
         check("rsp_vld", mem_bus.rsp_vld, 1);
         if (poke) begin
            mem_bus.req_vld = (i < 3);
            mem_bus.req_wr  = 1'b1;
            check("req_rdy_busy", mem_bus.req_rdy, 0);
         end
         if (i == abort_beat) begin
            rst_n = 1'b0;
            #1;
            check("rst_rsp_vld", mem_bus.rsp_vld, 0);
            check("rst_rsp_last", mem_bus.rsp_last, 0);
            check("rst_rsp_dat", mem_bus.rsp_dat, 0);
            check("rst_rsp_beat", mem_bus.rsp_beat, 0);
            check("rst_wdat_rdy", mem_bus.wdat_rdy, 0);
            check("rst_wack", mem_bus.wack, 0);
            sb_q.delete();
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check("rst_req_rdy", mem_bus.req_rdy, 1);
            $display("read addr=%08h aborted by reset at beat %0d", addr, i);
            return;
         end
         if (i == stall_beat) begin
            mem_bus.rsp_rdy = 1'b0;
            repeat (stall_n) begin
               @(negedge clk);
               check("stall_vld", mem_bus.rsp_vld, 1);
               check("stall_dat", mem_bus.rsp_dat, e.dat);
               check("stall_beat", mem_bus.rsp_beat, e.beat);
            end
            mem_bus.rsp_rdy = 1'b1;
         end
         e = sb_q.pop_front();
         check("rsp_dat", mem_bus.rsp_dat, e.dat);
         check("rsp_beat", mem_bus.rsp_beat, e.beat);
         check("rsp_last", mem_bus.rsp_last, e.last);
         @(posedge clk); @(negedge clk);
      end
      check("end_rsp_vld", mem_bus.rsp_vld, 0);
      check("end_req_rdy", mem_bus.req_rdy, 1);
      check("sb_empty", sb_q.size(), 0);
      $display("read addr=%08h start_bank=%0d stall_beat=%0d", addr, st, stall_beat);
   endtask

   initial begin
      mem_bus.req_vld  = 1'b0;
      mem_bus.req_wr   = 1'b0;
      mem_bus.req_addr = '0;
      mem_bus.wdat_vld = 1'b0;
      mem_bus.wdat     = '0;
      mem_bus.rsp_rdy  = 1'b1;
      da = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
             64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
      db = '{64'hA5A5_0000_0000_0001, 64'hA5A5_0000_0000_0002,
             64'hA5A5_0000_0000_0003, 64'hA5A5_0000_0000_0004};
      dc = '{64'hC0DE_0000_0000_1000, 64'hC0DE_0000_0000_2000,
             64'hC0DE_0000_0000_3000, 64'hC0DE_0000_0000_4000};

      repeat (2) @(negedge clk);
      check("reset_rsp_vld", mem_bus.rsp_vld, 0);
      check("reset_wdat_rdy", mem_bus.wdat_rdy, 0);
      check("reset_rsp_last", mem_bus.rsp_last, 0);
      check("reset_wack", mem_bus.wack, 0);
      check("reset_rsp_dat", mem_bus.rsp_dat, 0);
      check("reset_rsp_beat", mem_bus.rsp_beat, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_req_rdy", mem_bus.req_rdy, 1);

      // Read issued the cycle after wack must see the new line.
      write_line(32'h0000_0040, da);
      read_line(32'h0000_0040, -1, 0, -1, 1'b0);

      write_line(32'h0000_0000, db);
      @(negedge clk);
      mem_bus.wdat_vld = 1'b1;
      mem_bus.wdat     = 64'hDEAD_BEEF_DEAD_BEEF;
      repeat (3) begin
         @(negedge clk);
         check("wdat_rdy_idle", mem_bus.wdat_rdy, 0);
      end
      mem_bus.wdat_vld = 1'b0;
      read_line(32'h0000_8000, -1, 0, -1, 1'b0);

      read_line(32'h0000_0050, 1, 3, -1, 1'b1);

      write_line(32'h0000_7FE0, dc);
      read_line(32'h0000_7FF8, -1, 0, -1, 1'b0);

      read_line(32'h0000_0040, -1, 0, 2, 1'b0);
      read_line(32'h0000_0040, -1, 0, -1, 1'b0);
      read_line(32'h0000_0000, 2, 2, -1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
